// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, FSM encoding, frame layout.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OVS       = 16;
  localparam int OVS_W     = 4;
  localparam int SAMPLE_PT = 7;
  localparam int BIT_CNT_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_BREAK = 3'd6;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
  } frame_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running x16 oversample tick divider.
// clr_i restarts the phase so the next tick lands DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  assign tick_o = (cnt_q == LAST) && !clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver assembling two bytes into one {cmd,addr} frame.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        ferr_o,
  output logic        tout_o,
  output logic        perr_o
);

  localparam int DIV      = CLK_HZ / (BAUD * OVS);
  localparam int TO_TICKS = TIMEOUT_BITS * OVS;
  localparam int CW       = $clog2(TO_TICKS + 1);
  localparam logic [CW-1:0] TO_END  = CW'(TO_TICKS - 1);
  localparam logic [CW-1:0] BRK_END = CW'(OVS - 1);
  localparam logic [OVS_W-1:0] MID  = OVS_W'(SAMPLE_PT);

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0] arm_q;
  logic tick, clr, fall, mid, rxs;

  logic [2:0]           state_q, state_d;
  logic [OVS_W-1:0]     ovs_q, ovs_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           hi_q, hi_d;
  logic                 byte_idx_q, byte_idx_d;
  logic                 drop_q, drop_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  frame_t               data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tout_q, tout_d;
  logic                 perr_d;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .tick_o (tick)
  );

  // arm_q holds off edge detection until the synchronizer carries real line data
  assign rxs  = rx_s2_q;
  assign fall = arm_q[2] & rx_prev_q & ~rx_s2_q;
  assign mid  = tick && (ovs_q == MID);

  always_comb begin
    state_d    = state_q;
    ovs_d      = tick ? ovs_q + OVS_W'(1) : ovs_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    byte_idx_d = byte_idx_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tout_d     = 1'b0;
    perr_d     = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          clr     = 1'b1;
          ovs_d   = '0;
          drop_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (mid) begin
          bit_d = '0;
          if (!rxs) begin
            state_d = ST_DATA;
          end else begin
            byte_idx_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (mid) begin
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + BIT_CNT_W'(1);
          if (bit_q == '1) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PAR: begin
        if (mid) begin
          if (rxs != even_par(shift_q)) begin
            perr_d = 1'b1;
            drop_d = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (mid) begin
          if (!rxs) begin
            ferr_d     = !drop_q;
            byte_idx_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_BREAK;
          end else if (drop_q) begin
            byte_idx_d = 1'b0;
            state_d    = ST_IDLE;
          end else if (!byte_idx_q) begin
            hi_d       = shift_q;
            byte_idx_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_GAP;
          end else begin
            data_d     = '{cmd: hi_q, addr: shift_q};
            valid_d    = 1'b1;
            byte_idx_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (fall) begin
          clr     = 1'b1;
          ovs_d   = '0;
          state_d = ST_START;
        end else if (tick) begin
          if (cnt_q == TO_END) begin
            tout_d     = 1'b1;
            byte_idx_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_BREAK: begin
        if (!rxs) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == BRK_END) state_d = ST_IDLE;
          else                  cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        byte_idx_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      arm_q      <= '0;
      state_q    <= ST_IDLE;
      ovs_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      hi_q       <= '0;
      byte_idx_q <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      arm_q      <= {arm_q[1:0], 1'b1};
      state_q    <= state_d;
      ovs_q      <= ovs_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      byte_idx_q <= byte_idx_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      tout_q     <= tout_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign perr_o = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_d;
  assign perr_o      = 1'b0;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign ferr_o  = ferr_q;
  assign tout_o  = tout_q;

endmodule
